// File: rtl/arb_pkg.sv
// Shared sizes, FSM state type and one-hot helper for the round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // The only way a grant vector is ever built, so the grant can never be multi-hot.
  function automatic logic [N_REQ-1:0] onehot8(input logic [IDX_W-1:0] idx);
    onehot8 = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/onehot_rr_arbiter_rr_pick.sv
// Rotating-priority picker: first unmasked set bit of i_req scanning i_start, i_start+1, ... mod 8.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   i_req   [7:0] candidate request vector
//   i_start [2:0] first index examined by the scan
//   i_mask  [7:0] bits excluded from the scan
//   o_found       some unmasked request exists
//   o_idx   [2:0] index of the chosen request (i_start when nothing found)
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_start,
  input  logic [N_REQ-1:0] i_mask,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);

  logic [N_REQ-1:0] w_cand;

  assign w_cand = i_req & ~i_mask;

  // Walk from the furthest offset back to offset 0 so the nearest hit is written last.
  // The 3-bit add wraps index 7 back to 0 on its own.
  always_comb begin
    logic [IDX_W-1:0] w_pos;
    o_found = 1'b0;
    o_idx   = i_start;
    w_pos   = i_start;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_pos = i_start + IDX_W'(k);
      if (w_cand[w_pos]) begin
        o_found = 1'b1;
        o_idx   = w_pos;
      end
    end
  end

endmodule

// File: rtl/onehot_rr_arbiter.sv
// Eight-way round-robin arbiter with grant hold and bounded tenure, registered one-hot grant.
// Latency: req sampled on edge k is reflected in o_grant right after edge k; no req->grant comb path.
// Backpressure: none; requesters keep req high until served, the owner releases by dropping req.
//
// Ports:
//   i_clk               system clock, rising edge
//   i_rst               asynchronous active-high reset
//   i_req         [7:0] level-sensitive request vector
//   o_grant       [7:0] registered grant, one-hot or zero
//   o_grant_valid       registered OR-reduction of o_grant
module onehot_rr_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_REQ-1:0] i_req,
  output logic [N_REQ-1:0] o_grant,
  output logic             o_grant_valid
);

  // MAX_HOLD=0 turns preemption off; keep a 1-bit counter so widths stay legal.
  localparam int                HOLD_W     = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST  = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;
  localparam logic              PREEMPT_EN = (MAX_HOLD > 0);

  arb_state_t        r_state;
  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  r_owner;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [N_REQ-1:0]  r_grant;
  logic              r_grant_valid;

  arb_state_t        w_state_nxt;
  logic [IDX_W-1:0]  w_ptr_nxt;
  logic [IDX_W-1:0]  w_owner_nxt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic [N_REQ-1:0]  w_grant_nxt;

  logic [IDX_W-1:0]  w_pick_start;
  logic [N_REQ-1:0]  w_pick_mask;
  logic              w_pick_found;
  logic [IDX_W-1:0]  w_pick_idx;
  logic              w_at_limit;
  logic              w_take;

  // While busy the scan starts after the owner with the owner masked, so on preemption the
  // owner goes last; on release its bit is already clear, so the mask changes nothing.
  assign w_pick_start = (r_state == BUSY) ? (r_owner + IDX_W'(1)) : r_ptr;
  assign w_pick_mask  = (r_state == BUSY) ? onehot8(r_owner) : '0;
  assign w_at_limit   = PREEMPT_EN && (r_hold_cnt == HOLD_LAST);

  rr_pick u_pick (
    .i_req   (i_req),
    .i_start (w_pick_start),
    .i_mask  (w_pick_mask),
    .o_found (w_pick_found),
    .o_idx   (w_pick_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_hold_nxt  = r_hold_cnt;
    w_grant_nxt = r_grant;
    w_take      = 1'b0;

    if (r_state == IDLE) begin
      w_take = w_pick_found;
    end else if (!i_req[r_owner]) begin
      // Release beats expiry; hand over back-to-back if anyone else is waiting.
      if (w_pick_found) begin
        w_take = 1'b1;
      end else begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    end else if (w_at_limit && w_pick_found) begin
      w_take = 1'b1;
    end else if (w_at_limit) begin
      // Tenure expired with nobody waiting: restart the window instead of wrapping.
      w_hold_nxt = '0;
    end else if (r_hold_cnt != HOLD_LAST) begin
      w_hold_nxt = r_hold_cnt + HOLD_W'(1);
    end

    if (w_take) begin
      w_state_nxt = BUSY;
      w_owner_nxt = w_pick_idx;
      w_grant_nxt = onehot8(w_pick_idx);
      w_ptr_nxt   = w_pick_idx + IDX_W'(1);
      w_hold_nxt  = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_owner       <= '0;
      r_hold_cnt    <= '0;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ptr         <= w_ptr_nxt;
      r_owner       <= w_owner_nxt;
      r_hold_cnt    <= w_hold_nxt;
      r_grant       <= w_grant_nxt;
      r_grant_valid <= |w_grant_nxt;
    end
  end

  assign o_grant       = r_grant;
  assign o_grant_valid = r_grant_valid;

endmodule

// File: doc/onehot_rr_arbiter.md
# onehot_rr_arbiter

Eight-requester round-robin arbiter with grant hold and bounded tenure. It produces a registered one-hot grant vector that drives the 8-to-3 one-hot encoder directly downstream, which turns the grant into a 3-bit index. The grant is always exactly one-hot or all-zero, never multi-hot, because the encoder's output is undefined for any other pattern.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive cycles one owner may hold the grant while others wait. 0 disables preemption.
- `clk`  input  1  system clock; all state is updated on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `req`  input  8  request vector; bit i is requester i. Level-sensitive; any number of bits may be set.
- `grant`  output  8  registered grant; exactly one bit set when `grant_valid`=1, otherwise 8'h00.
- `grant_valid`  output  1  registered; equals OR-reduction of `grant`.

## Operation
- Internal state:
  - FSM: IDLE or BUSY.
  - `ptr[2:0]`: search start point.
  - `owner[2:0]`: current grantee.
  - `hold_cnt`: width clog2(MAX_HOLD+1).
- Pick function: the first set bit of `req` found by scanning indices ptr, ptr+1, … mod 8. The scan wraps from 7 to 0.
- **IDLE**
  - If `req` = 0: stay in IDLE; `grant` = 0.
  - Else: `owner` ← pick, `grant` ← onehot(pick), `ptr` ← pick+1 mod 8, `hold_cnt` ← 0, go to BUSY.
- **BUSY** (evaluated each edge, in priority order):
  1. Release: `req[owner]` = 0. If other requests are pending, grant the pick immediately, starting the scan at owner+1 (back-to-back, no idle cycle). Otherwise `grant` ← 0 and go to IDLE.
  2. Preempt: `MAX_HOLD` ≠ 0, `hold_cnt` = MAX_HOLD−1, and some other `req` bit is set. Grant the pick, scanning from owner+1 with the owner's bit masked, so the owner goes last. The owner's request stays pending.
  3. Expiry with no contender: keep the grant, `hold_cnt` ← 0.
  4. Otherwise: keep the grant, `hold_cnt` ← `hold_cnt` + 1. The counter saturates at MAX_HOLD−1 and never wraps.
- Every new grant sets `ptr` ← new owner + 1 mod 8 and clears `hold_cnt`.
- A new request that appears during BUSY never preempts the owner early. It waits for release or expiry.
- `grant` is written only from onehot(index) or 0. Multi-hot values are structurally impossible.

## Timing
- Reset values: `grant` = 8'h00, `grant_valid` = 0, `ptr` = 0, `owner` = 0, `hold_cnt` = 0, FSM = IDLE.
- Reset is asynchronous: outputs clear immediately when `rst` rises, including mid-tenure. The first grant after reset is evaluated on the first rising edge with `rst` low, with `ptr` = 0.
- Latency:
  - `req` sampled at edge k → `grant` valid after edge k (one cycle).
  - Release: owner drops `req` before edge k → old grant gone and next grant present after edge k.
- Maximum tenure under contention: MAX_HOLD cycles.
- Worst-case wait for a continuously requesting requester: 7×MAX_HOLD cycles.
- Simultaneous release and expiry: release takes priority. The owner is not re-selected unless it is the only requester.
- No combinational path from `req` to `grant`.

## Structure
- Package `arb_pkg`:
  - `N_REQ` = 8, `IDX_W` = 3.
  - State enum `arb_state_t` {IDLE, BUSY}.
  - Function `onehot8(idx)`.
- Sub-module `rr_pick`: purely combinational rotating-priority picker.
  - Inputs: `req[7:0]`, `start[2:0]`, `mask[7:0]`.
  - Outputs: `found`, `idx[2:0]`.
- Top level: FSM, registers, and hold counter.

## Test plan
- **Reset and idle:** hold `rst`=1, then release with `req`=8'h00 → `grant`=8'h00 and `grant_valid`=0 on every cycle. Then assert `rst` mid-grant → `grant` clears without waiting for a clock edge.
- **Single request:** `req`=8'h10 → `grant`=8'h10 one cycle later. Hold `req` for 40 cycles → grant stays 8'h10, with no preemption since there is no contender. Drop `req` → `grant`=8'h00 next cycle.
- **Rotation:** `req`=8'hFF; each owner drops its bit for one cycle after being granted, then re-asserts it → grant sequence 01, 02, 04, … 80, 01, with no idle cycles between grants.
- **Wrap and pointer:** owner 6 (8'h40) releases while `req`=8'h83 → next grant is 8'h80, then 8'h01, then 8'h02.
- **Preemption with MAX_HOLD=4:** `req`=8'h05 held constant → grant 8'h01 for exactly 4 cycles, then 8'h04 for 4 cycles, then 8'h01, and so on.
- **One-hot invariant:** random `req` for 10k cycles → `$onehot0(grant)` always holds and `grant_valid` == |`grant`. Feeding `grant` to the downstream encoder never produces X when `grant_valid`=1.
